// File: rtl/code4_onehot10_strobe_pkg.sv
// Shared definitions for the 4-bit code <-> 10-bit one-hot strobe family.
package code4_onehot10_strobe_pkg;

   localparam int unsigned CODE_W   = 4;
   localparam int unsigned ONEHOT_W = 10;

   localparam logic [CODE_W-1:0] CODE_NOHOT = 4'hF;
   localparam logic [CODE_W-1:0] CODE_MIN   = 4'd1;
   localparam logic [CODE_W-1:0] CODE_MAX   = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/code4_onehot10_strobe_if.sv
// Code-source handshake: source drives valid/code, strobe block drives ready.
interface code4_onehot10_strobe_if;
   import code4_onehot10_strobe_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] in_code;

   modport master (output in_valid, output in_code, input in_ready);
   modport slave  (input in_valid, input in_code, output in_ready);

endinterface

// File: rtl/code4_onehot10_strobe_dec_comb.sv
// Pure combinational code -> one-hot decode with legal / no-hot classification.
module onehot10_dec_comb
   import code4_onehot10_strobe_pkg::*;
(
   input  logic [CODE_W-1:0]   code,
   output logic [ONEHOT_W-1:0] onehot,
   output logic                legal,
   output logic                nohot
);

   // Classify the code and form the matching single-bit strobe.
   always_comb begin
      legal  = (code >= CODE_MIN) && (code <= CODE_MAX);
      nohot  = (code == CODE_NOHOT);
      onehot = '0;
      if (legal) begin
         onehot = ONEHOT_W'(1) << (code - CODE_MIN);
      end
   end

endmodule

// File: rtl/code4_onehot10_strobe.sv
// Accepts a 4-bit code and drives the matching one-hot strobe for HOLD_CYCLES,
// then enforces GAP_CYCLES of not-ready before the next code.
module code4_onehot10_strobe
   import code4_onehot10_strobe_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1,
   parameter int CNT_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   code4_onehot10_strobe_if.slave bus,
   output logic [ONEHOT_W-1:0]    onehot,
   output logic                   onehot_valid,
   output logic                   nohot_pulse,
   output logic [CNT_W-1:0]       illegal_cnt,
   output logic                   busy
);

   generate
      if (HOLD_CYCLES < 1) begin : g_bad_hold
         $error("HOLD_CYCLES must be >= 1");
      end
      if (GAP_CYCLES < 0) begin : g_bad_gap
         $error("GAP_CYCLES must be >= 0");
      end
   endgenerate

   localparam int HG_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CT_MAX = (HG_MAX > 2) ? HG_MAX : 2;
   localparam int CT_W   = $clog2(CT_MAX);

   state_t                state_q, state_d;
   logic [CT_W-1:0]       cnt_q, cnt_d;
   logic [ONEHOT_W-1:0]   onehot_q, onehot_d;
   logic                  nohot_q, nohot_d;
   logic [CNT_W-1:0]      illegal_q, illegal_d;

   logic [ONEHOT_W-1:0]   dec_onehot;
   logic                  dec_legal;
   logic                  dec_nohot;
   logic                  accept;

   onehot10_dec_comb u_dec (
      .code   (bus.in_code),
      .onehot (dec_onehot),
      .legal  (dec_legal),
      .nohot  (dec_nohot)
   );

   assign bus.in_ready = (state_q == ST_IDLE);
   assign accept       = bus.in_valid && (state_q == ST_IDLE);

   // Next-state, counter and output-register computation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      onehot_d  = '0;
      nohot_d   = 1'b0;
      illegal_d = illegal_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (dec_legal) begin
                  state_d  = ST_HOLD;
                  cnt_d    = CT_W'(HOLD_CYCLES - 1);
                  onehot_d = dec_onehot;
               end else if (dec_nohot) begin
                  nohot_d = 1'b1;
               end else if (illegal_q != '1) begin
                  illegal_d = illegal_q + CNT_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == '0) begin
               if (GAP_CYCLES > 0) begin
                  state_d = ST_GAP;
                  cnt_d   = CT_W'(GAP_CYCLES - 1);
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d    = cnt_q - CT_W'(1);
               onehot_d = onehot_q;
            end
         end
         ST_GAP: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any strobe in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         onehot_q  <= '0;
         nohot_q   <= 1'b0;
         illegal_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         onehot_q  <= onehot_d;
         nohot_q   <= nohot_d;
         illegal_q <= illegal_d;
      end
   end

   assign onehot       = onehot_q;
   assign onehot_valid = (state_q == ST_HOLD);
   assign nohot_pulse  = nohot_q;
   assign illegal_cnt  = illegal_q;
   assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_code4_onehot10_strobe.sv
// Directed bench for code4_onehot10_strobe: default, narrow-counter and
// zero-gap/single-hold configurations driven from one linear sequence.
module tb_code4_onehot10_strobe;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   code4_onehot10_strobe_if a_if ();
   code4_onehot10_strobe_if b_if ();
   code4_onehot10_strobe_if c_if ();

   logic [9:0] a_onehot, b_onehot, c_onehot;
   logic       a_ov, b_ov, c_ov;
   logic       a_nh, b_nh, c_nh;
   logic [7:0] a_ill;
   logic [1:0] b_ill;
   logic [7:0] c_ill;
   logic       a_busy, b_busy, c_busy;

   code4_onehot10_strobe u_a (
      .clk (clk), .rst_n (rst_n), .bus (a_if.slave),
      .onehot (a_onehot), .onehot_valid (a_ov), .nohot_pulse (a_nh),
      .illegal_cnt (a_ill), .busy (a_busy)
   );

   code4_onehot10_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(2)) u_b (
      .clk (clk), .rst_n (rst_n), .bus (b_if.slave),
      .onehot (b_onehot), .onehot_valid (b_ov), .nohot_pulse (b_nh),
      .illegal_cnt (b_ill), .busy (b_busy)
   );

   code4_onehot10_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(8)) u_c (
      .clk (clk), .rst_n (rst_n), .bus (c_if.slave),
      .onehot (c_onehot), .onehot_valid (c_ov), .nohot_pulse (c_nh),
      .illegal_cnt (c_ill), .busy (c_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference 10-bit one-hot -> 4-bit code encoder (4'hF for none/multi).
   function automatic logic [3:0] enc10(input logic [9:0] v);
      int unsigned ones;
      logic [3:0]  code;
      ones = 0;
      code = 4'hF;
      for (int i = 0; i < 10; i++) begin
         if (v[i]) begin
            ones++;
            code = 4'(i + 1);
         end
      end
      return (ones == 1) ? code : 4'hF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      a_if.in_valid = 1'b0; a_if.in_code = 4'd0;
      b_if.in_valid = 1'b0; b_if.in_code = 4'd0;
      c_if.in_valid = 1'b0; c_if.in_code = 4'd0;
      step();
      step();
      rst_n = 1'b1;
      step();

      // 1: reset asserted mid-HOLD clears outputs immediately
      a_if.in_valid = 1'b1; a_if.in_code = 4'd5;
      step();
      a_if.in_valid = 1'b0;
      chk("rst_pre_onehot", 32'(a_onehot), 32'h010);
      step();
      rst_n = 1'b0;
      #1;
      chk("rst_onehot", 32'(a_onehot), 32'h000);
      chk("rst_busy", 32'(a_busy), 32'h0);
      chk("rst_ill", 32'(a_ill), 32'h0);
      chk("rst_ov", 32'(a_ov), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("rst_ready", 32'(a_if.in_ready), 32'h1);
      chk("rst_post_onehot", 32'(a_onehot), 32'h000);

      // 2: code 3 -> 4 cycles of bit 2, 1 gap cycle, then ready
      a_if.in_valid = 1'b1; a_if.in_code = 4'd3;
      step();
      a_if.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("hold%0d_onehot", i), 32'(a_onehot), 32'h004);
         chk($sformatf("hold%0d_ov", i), 32'(a_ov), 32'h1);
         chk($sformatf("hold%0d_ready", i), 32'(a_if.in_ready), 32'h0);
         step();
      end
      chk("gap_onehot", 32'(a_onehot), 32'h000);
      chk("gap_ready", 32'(a_if.in_ready), 32'h0);
      chk("gap_busy", 32'(a_busy), 32'h1);
      step();
      chk("idle_ready", 32'(a_if.in_ready), 32'h1);
      chk("idle_busy", 32'(a_busy), 32'h0);

      // 3: sweep codes 1..10 with round-trip through the encoder
      for (int c = 1; c <= 10; c++) begin
         a_if.in_valid = 1'b1; a_if.in_code = 4'(c);
         step();
         a_if.in_valid = 1'b0;
         chk($sformatf("sweep%0d_onehot", c), 32'(a_onehot), 32'(10'(1) << (c - 1)));
         chk($sformatf("sweep%0d_enc", c), 32'(enc10(a_onehot)), 32'(c));
         for (int k = 0; k < 5; k++) step();
         chk($sformatf("sweep%0d_ready", c), 32'(a_if.in_ready), 32'h1);
      end

      // 4: 4'hF then 4'd12 back to back
      a_if.in_valid = 1'b1; a_if.in_code = 4'hF;
      step();
      chk("nohot_pulse", 32'(a_nh), 32'h1);
      chk("nohot_onehot", 32'(a_onehot), 32'h000);
      chk("nohot_ready", 32'(a_if.in_ready), 32'h1);
      chk("nohot_ill", 32'(a_ill), 32'h0);
      a_if.in_code = 4'd12;
      step();
      a_if.in_valid = 1'b0;
      chk("ill_pulse", 32'(a_nh), 32'h0);
      chk("ill_cnt", 32'(a_ill), 32'h1);
      chk("ill_ready", 32'(a_if.in_ready), 32'h1);
      chk("ill_onehot", 32'(a_onehot), 32'h000);
      step();
      chk("ill_cnt_keep", 32'(a_ill), 32'h1);
      chk("nohot_once", 32'(a_nh), 32'h0);

      // 5: CNT_W=2 saturates at 3
      b_if.in_valid = 1'b1;
      b_if.in_code = 4'd0;  step(); chk("sat1", 32'(b_ill), 32'h1);
      b_if.in_code = 4'd11; step(); chk("sat2", 32'(b_ill), 32'h2);
      b_if.in_code = 4'd12; step(); chk("sat3", 32'(b_ill), 32'h3);
      b_if.in_code = 4'd13; step(); chk("sat4", 32'(b_ill), 32'h3);
      b_if.in_code = 4'd14; step(); chk("sat5", 32'(b_ill), 32'h3);
      b_if.in_valid = 1'b0;
      chk("sat_ready", 32'(b_if.in_ready), 32'h1);

      // 6: GAP=0, HOLD=1, valid held: 0x001, one zero cycle, 0x200
      c_if.in_valid = 1'b1; c_if.in_code = 4'd1;
      step();
      chk("b2b_first", 32'(c_onehot), 32'h001);
      chk("b2b_first_ready", 32'(c_if.in_ready), 32'h0);
      c_if.in_code = 4'd10;
      step();
      chk("b2b_zero", 32'(c_onehot), 32'h000);
      chk("b2b_zero_ready", 32'(c_if.in_ready), 32'h1);
      step();
      c_if.in_valid = 1'b0;
      chk("b2b_second", 32'(c_onehot), 32'h200);
      chk("b2b_second_ov", 32'(c_ov), 32'h1);
      step();
      chk("b2b_end", 32'(c_onehot), 32'h000);
      chk("b2b_end_busy", 32'(c_busy), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
